// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : Transmit sequencer for the UART register bank. Takes the
//               pending-byte flag, data byte, divisor and stop-bit setting,
//               serialises one 8N1/8N2 frame (LSB first) on tx, and pulses
//               tx_done for one cycle at frame end so the bank can clear its
//               full flag.
//
// Ports       : clk          - core clock, all logic on posedge
//               rst_n        - synchronous active-low reset
//               tx_start     - transmitter enable from the control register
//               full         - byte pending in the data register
//               data_in      - byte to send
//               dvsr         - bit-period divisor, bit period = dvsr+1 clocks
//               two_stop_bit - 1 = two stop bits, 0 = one
//               tx           - serial line, idle high, driven from a flop
//               tx_busy      - frame in progress
//               tx_done      - one-cycle pulse at frame end
//
// Options     : `define UART_PARITY_EN adds an even-parity bit between the
//               last data bit and the stop bit(s).
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_W = 8,
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_start,
    input  logic              full,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              two_stop_bit,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_W - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd5;
`endif

    logic [2:0]         r_state;
    logic [DVSR_W-1:0]  r_baud_cnt;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic               r_stop_idx;
    logic [DATA_W-1:0]  r_data_sh;
    logic [DVSR_W-1:0]  r_dvsr_sh;
    logic               r_two_stop_sh;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    // Last clock of the current bit period (counter has reached the latched divisor).
    logic               w_bit_end;
    logic [c_IDX_W-1:0] w_next_idx;

    assign w_bit_end  = (r_baud_cnt == r_dvsr_sh);
    assign w_next_idx = r_bit_idx + 1'b1;

    // All outputs are registered; the value written to r_tx at a transition
    // is the line level for the state being entered, so tx has no glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_baud_cnt    <= '0;
            r_bit_idx     <= '0;
            r_stop_idx    <= 1'b0;
            r_data_sh     <= '0;
            r_dvsr_sh     <= '0;
            r_two_stop_sh <= 1'b0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= '0;
                    if (tx_start && full) begin
                        // Frame parameters are frozen here for the whole frame.
                        r_data_sh     <= data_in;
                        r_dvsr_sh     <= dvsr;
                        r_two_stop_sh <= two_stop_bit;
                        r_bit_idx     <= '0;
                        r_stop_idx    <= 1'b0;
                        r_tx          <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= c_START;
                    end
                end

                c_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_data_sh[0];
                        r_state    <= c_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                c_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == c_LAST_IDX) begin
`ifdef UART_PARITY_EN
                            r_tx    <= ^r_data_sh;
                            r_state <= c_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
`endif
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_data_sh[w_next_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

`ifdef UART_PARITY_EN
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b1;
                        r_state    <= c_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`endif

                c_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        // Second stop bit is just another P-clock period at high.
                        if (r_two_stop_sh && !r_stop_idx) begin
                            r_stop_idx <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                c_DONE: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= '0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl. Each frame's expected
//               line waveform is built from the frame rules (start bit, data
//               LSB first, optional even parity, stop bits, each held
//               dvsr+1 clocks) and compared cycle by cycle together with
//               tx_busy and tx_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

`ifdef UART_PARITY_EN
    localparam bit c_PAR_EN = 1'b1;
`else
    localparam bit c_PAR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        tx_start;
    logic        full;
    logic [7:0]  data_in;
    logic [10:0] dvsr;
    logic        two_stop_bit;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int n_vec;
    int n_miss;

    uart_tx_ctrl #(
        .DATA_W (8),
        .DVSR_W (11)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_start     (tx_start),
        .full         (full),
        .data_in      (data_in),
        .dvsr         (dvsr),
        .two_stop_bit (two_stop_bit),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expect the idle line ({tx,busy,done} = 100) for n cycles.
    task automatic idle_check(input string name, input int n);
        logic [2:0] got;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got = {tx, tx_busy, tx_done};
            n_vec++;
            if (got !== 3'b100) begin
                n_miss++;
                $display("FAIL %s idle cycle %0d: {tx,busy,done} got %b want 100", name, i, got);
            end
        end
    endtask

    // Drives one frame request and checks every cycle of the frame plus the
    // DONE cycle. Must be called between edges while the DUT is idle; the
    // next posedge is the one that samples tx_start && full.
    task automatic check_frame(input string name, input logic [7:0] d, input logic [10:0] dv,
                               input logic ts, input int mut_at, input logic [7:0] md,
                               input logic [10:0] mdv, input logic mts,
                               input logic drop_start, input logic keep_full);
        int         p;
        int         k;
        logic       exp_bits[$];
        logic [2:0] got;
        logic [2:0] exp;
        p = int'(dv) + 1;
        data_in      = d;
        dvsr         = dv;
        two_stop_bit = ts;
        full         = 1'b1;
        tx_start     = 1'b1;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (c_PAR_EN) exp_bits.push_back(^d);
        exp_bits.push_back(1'b1);
        if (ts) exp_bits.push_back(1'b1);
        @(posedge clk);
        k = 0;
        foreach (exp_bits[b]) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                got = {tx, tx_busy, tx_done};
                exp = {exp_bits[b], 1'b1, 1'b0};
                n_vec++;
                if (got !== exp) begin
                    n_miss++;
                    $display("FAIL %s cycle %0d (bit %0d): {tx,busy,done} got %b want %b",
                             name, k, b, got, exp);
                end
                if (k == 0) begin
                    if (!keep_full) full = 1'b0;
                    if (drop_start) tx_start = 1'b0;
                end
                if (k == mut_at) begin
                    data_in      = md;
                    dvsr         = mdv;
                    two_stop_bit = mts;
                end
                k++;
            end
        end
        @(negedge clk);
        got = {tx, tx_busy, tx_done};
        n_vec++;
        if (got !== 3'b101) begin
            n_miss++;
            $display("FAIL %s done cycle %0d: {tx,busy,done} got %b want 101", name, k, got);
        end
        // Bank reaction to tx_done: clear full unless another byte is queued.
        full = keep_full;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst_n        = 1'b0;
        tx_start     = 1'b1;
        full         = 1'b1;
        data_in      = 8'($urandom);
        dvsr         = 11'd2;
        two_stop_bit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {tx, tx_busy, tx_done};
            n_vec++;
            if (got !== 3'b100) begin
                n_miss++;
                $display("FAIL reset cycle %0d: {tx,busy,done} got %b want 100", i, got);
            end
        end
        rst_n = 1'b1;
        check_frame("reset_release", 8'($urandom), 11'd1, 1'b0, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("reset_release_after", 3);
    endtask

    task automatic test_basic();
        check_frame("basic_a5", 8'hA5, 11'd3, 1'b0, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("basic_after", 3);
    endtask

    task automatic test_two_stop_min();
        check_frame("two_stop_p1", 8'h00, 11'd0, 1'b1, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("two_stop_after", 2);
    endtask

    task automatic test_mid_change();
        check_frame("mid_change", 8'h3C, 11'd5, 1'b0, 20, 8'hFF, 11'd1, 1'b1, 1'b0, 1'b0);
        idle_check("mid_change_after", 2);
    endtask

    task automatic test_back_to_back();
        check_frame("b2b_first", 8'h55, 11'd2, 1'b0, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b1);
        idle_check("b2b_gap", 1);
        check_frame("b2b_second", 8'hAA, 11'd2, 1'b0, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("b2b_after", 3);
    endtask

    task automatic test_start_drop();
        check_frame("start_drop", 8'($urandom), 11'd1, 1'b1, -1, 8'h00, 11'd0, 1'b0, 1'b1, 1'b0);
        full = 1'b1;
        idle_check("start_drop_hold", 5);
        full     = 1'b0;
        tx_start = 1'b1;
        idle_check("no_full_hold", 3);
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        logic [2:0] got;
        logic [2:0] exp;
        logic       bits[$];
        d = 8'($urandom);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        data_in      = d;
        dvsr         = 11'd2;
        two_stop_bit = 1'b0;
        full         = 1'b1;
        tx_start     = 1'b1;
        @(posedge clk);
        // P = 3: data bit 3 occupies frame cycles 12..14.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            got = {tx, tx_busy, tx_done};
            exp = {bits[k / 3], 1'b1, 1'b0};
            n_vec++;
            if (got !== exp) begin
                n_miss++;
                $display("FAIL mid_reset pre cycle %0d: {tx,busy,done} got %b want %b", k, got, exp);
            end
            if (k == 0) full = 1'b0;
        end
        rst_n = 1'b0;
        idle_check("mid_reset_hold", 2);
        rst_n = 1'b1;
        idle_check("mid_reset_no_done", 3);
        check_frame("mid_reset_restart", 8'($urandom), 11'd2, 1'b1, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("mid_reset_after", 2);
    endtask

    task automatic test_parity();
        check_frame("parity_07", 8'h07, 11'd1, 1'b0, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("parity_after", 2);
    endtask

    task automatic test_max_dvsr();
        check_frame("max_dvsr", 8'($urandom), 11'd2047, 1'b0, -1, 8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
        idle_check("max_dvsr_after", 2);
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [10:0] dv;
        logic        ts;
        int          mut;
        logic        drop;
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom);
            dv   = 11'($urandom_range(0, 9));
            ts   = 1'($urandom);
            mut  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9 * (int'(dv) + 1))) : -1;
            drop = 1'($urandom);
            check_frame("random", d, dv, ts, mut, 8'($urandom), 11'($urandom_range(0, 9)),
                        1'($urandom), drop, 1'b0);
            if (drop) begin
                full = 1'b1;
                idle_check("random_start_drop", 3);
                full     = 1'b0;
                tx_start = 1'b1;
            end
            idle_check("random_gap", int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        tx_start     = 1'b0;
        full         = 1'b0;
        data_in      = 8'h00;
        dvsr         = 11'd0;
        two_stop_bit = 1'b0;
        test_reset();
        test_basic();
        test_two_stop_min();
        test_mid_change();
        test_back_to_back();
        test_start_drop();
        test_mid_reset();
        test_parity();
        test_random();
        test_max_dvsr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the UART memory-mapped register bank.
- Consumes the bank's pending-byte flag, data byte, divisor and stop-bit configuration, serialises one 8N1/8N2 frame on the tx line, and returns a one-cycle tx_done pulse so the bank clears its full flag.
- Sits between the UART register bank and the chip-level tx pin, in the core clock domain.

Parameters:
- DATA_W, 8, data bits per frame, sent LSB first.
- DVSR_W, 11, divisor width; must match the bank's divisor field.

Ports:
- clk  input  1  core clock; all logic on posedge.
- rst_n  input  1  reset: synchronous, active-low.
- tx_start  input  1  transmitter enable from the control register.
- full  input  1  byte pending in the data register.
- data_in  input  DATA_W  byte to send.
- dvsr  input  DVSR_W  bit-period divisor.
- two_stop_bit  input  1  1 = two stop bits, 0 = one.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=IDLE; tx=1; tx_busy=0; tx_done=0.
  - All counters and shadow registers cleared.
- Bit period: P = dvsr+1 clocks. dvsr=0 gives P=1; maximum P=2048.
  - Baud counter counts 0..dvsr, then wraps to 0 and advances the bit.
- FSM states: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - tx=1.
  - If tx_start && full, latch data_in, dvsr and two_stop_bit into shadow registers, then go to START.
  - Latched values are used for the whole frame; input changes mid-frame are ignored.
- START: tx=0 for P clocks, then DATA with bit index 0.
- DATA:
  - tx = shadow[idx] for P clocks per bit.
  - After idx=DATA_W-1, go to STOP. (With UART_PARITY_EN, go to PARITY instead; see Optional Feature.)
- STOP: tx=1 for P clocks (one stop bit) or 2P clocks (two stop bits), then DONE.
- DONE:
  - tx=1; tx_done=1 for exactly this one cycle; then IDLE.
- Latency: tx falls at the first posedge after the IDLE cycle that samples tx_start && full.
- Frame length: 10P clocks (one stop bit) or 11P clocks (two stop bits), followed by the 1-cycle DONE.
- tx_busy: 1 in START, DATA, STOP (and PARITY); 0 in IDLE and DONE.
- The register bank clears full in response to tx_done before the next posedge.
  - If full is still 1 in IDLE, a new frame starts. Back-to-back frames are separated by DONE plus one IDLE cycle.
- tx_start deasserted mid-frame: the current frame completes normally, then the block holds in IDLE.
- full deasserted mid-frame: no effect on the frame.
- Reset mid-frame:
  - tx=1 and state=IDLE at that edge.
  - No tx_done is issued and the partial frame is abandoned.
- No glitches on tx: driven from a register.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP: tx = XOR of the latched data bits (even parity) for P clocks.
  - Frame becomes 11P (one stop bit) or 12P (two stop bits).
  - tx_busy is 1 in PARITY.
- Undefined: PARITY state and its logic are absent; frame timing as above.

Test Plan:
- Reset: rst_n=0 for 3 cycles with tx_start=1, full=1 -> tx=1, tx_busy=0, tx_done=0. First frame starts only after rst_n=1.
- Basic frame: dvsr=3, data_in=8'hA5, two_stop_bit=0, tx_start=1, full=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks). tx_done pulses once at clock 41; full clears; tx stays 1.
- Two stop bits with dvsr=0: data_in=8'h00 -> start + 8 zeros 1 clock each, then stop high 2 clocks. tx_done is 1 cycle after the frame (11 clocks).
- Mid-frame input change: start with dvsr=5, data=8'h3C; after 20 clocks change data_in=8'hFF, dvsr=1, two_stop_bit=1 -> original frame completes with P=6 and one stop bit (60 clocks).
- Back-to-back: hold full=1 for two frames (bench reloads data 8'h55 then 8'hAA) -> two frames; tx_done pulses twice; gap between them is DONE + 1 IDLE cycle.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 at that edge, no tx_done; after release with full=1, a new frame starts from START.
- Parity (UART_PARITY_EN): data_in=8'h07, dvsr=1 -> parity bit 1, held 2 clocks before stop.
